// File: rtl/crc_checker.sv
// Bit-serial (7,4) CRC/Hamming checker, polynomial x^3+x^2+1.
// Computes the syndrome MSB-first and optionally corrects single-bit errors.
module crc_checker #(
    parameter bit CORRECT_EN = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       cw_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       data_out,
    output logic [2:0]       syndrome,
    output logic             err_detected,
    output logic             err_corrected,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cw_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [6:0]       shift_q, shift_d;
    logic [3:0]       cwdat_q, cwdat_d;
    logic [2:0]       lfsr_q, lfsr_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [3:0]       data_q, data_d;
    logic [2:0]       syn_q, syn_d;
    logic             errd_q, errd_d;
    logic             errc_q, errc_d;
    logic [CNT_W-1:0] cwcnt_q, cwcnt_d;
    logic [CNT_W-1:0] errcnt_q, errcnt_d;
    logic [2:0]       lfsr_step;
    logic [3:0]       fix;
    logic             accept;
    logic             handshake;

    assign in_ready      = (state_q == IDLE) & reset_n;
    assign out_valid     = (state_q == DONE);
    assign accept        = in_valid & in_ready;
    assign handshake     = out_valid & out_ready;
    assign data_out      = data_q;
    assign syndrome      = syn_q;
    assign err_detected  = errd_q;
    assign err_corrected = errc_q;
    assign cw_count      = cwcnt_q;
    assign err_count     = errcnt_q;

    assign lfsr_step = {lfsr_q[1:0], shift_q[6]} ^ (lfsr_q[2] ? 3'b101 : 3'b000);

    // Only syndromes pointing at codeword bits 6:3 touch the data nibble
    always_comb begin
        fix = 4'b0000;
        unique case (lfsr_step)
            3'b101:  fix = 4'b0001;
            3'b111:  fix = 4'b0010;
            3'b011:  fix = 4'b0100;
            3'b110:  fix = 4'b1000;
            default: fix = 4'b0000;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cwdat_d  = cwdat_q;
        lfsr_d   = lfsr_q;
        bitcnt_d = bitcnt_q;
        data_d   = data_q;
        syn_d    = syn_q;
        errd_d   = errd_q;
        errc_d   = errc_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d  = cw_in;
                    cwdat_d  = cw_in[6:3];
                    lfsr_d   = 3'b000;
                    bitcnt_d = 3'd0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                shift_d  = {shift_q[5:0], 1'b0};
                lfsr_d   = lfsr_step;
                bitcnt_d = bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd6) begin
                    state_d = DONE;
                    syn_d   = lfsr_step;
                    data_d  = cwdat_q ^ (CORRECT_EN ? fix : 4'b0000);
                    errd_d  = |lfsr_step;
                    errc_d  = (|lfsr_step) & CORRECT_EN;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cwcnt_d  = cwcnt_q;
        errcnt_d = errcnt_q;
        if (cnt_clr) begin
            cwcnt_d  = '0;
            errcnt_d = '0;
        end else if (handshake) begin
            if (cwcnt_q != CNT_MAX) cwcnt_d = cwcnt_q + CNT_ONE;
            if (errd_q && errcnt_q != CNT_MAX) errcnt_d = errcnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            cwdat_q  <= '0;
            lfsr_q   <= '0;
            bitcnt_q <= '0;
            data_q   <= '0;
            syn_q    <= '0;
            errd_q   <= 1'b0;
            errc_q   <= 1'b0;
            cwcnt_q  <= '0;
            errcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cwdat_q  <= cwdat_d;
            lfsr_q   <= lfsr_d;
            bitcnt_q <= bitcnt_d;
            data_q   <= data_d;
            syn_q    <= syn_d;
            errd_q   <= errd_d;
            errc_q   <= errc_d;
            cwcnt_q  <= cwcnt_d;
            errcnt_q <= errcnt_d;
        end
    end

endmodule

// File: tb/tb_crc_checker.sv
// Scoreboard bench for crc_checker: correcting 16-bit-counter instance
// and a detect-only 2-bit-counter instance driven in lockstep.
module tb_crc_checker;

    typedef struct {
        logic [3:0] da;
        logic [3:0] db;
        logic [2:0] syn;
        logic       err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [6:0]  cw_in = 7'h00;
    logic        out_ready = 1'b0;
    logic        cnt_clr = 1'b0;

    logic        a_in_ready, a_out_valid, a_err_detected, a_err_corrected;
    logic [3:0]  a_data_out;
    logic [2:0]  a_syndrome;
    logic [15:0] a_cw_count, a_err_count;
    logic        b_in_ready, b_out_valid, b_err_detected, b_err_corrected;
    logic [3:0]  b_data_out;
    logic [2:0]  b_syndrome;
    logic [1:0]  b_cw_count, b_err_count;

    int   n_chk = 0;
    int   n_fail = 0;
    int   ea_cw = 0, ea_err = 0, eb_cw = 0, eb_err = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    crc_checker #(.CORRECT_EN(1'b1), .CNT_W(16)) u_a (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(a_in_ready), .cw_in(cw_in),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .data_out(a_data_out), .syndrome(a_syndrome),
        .err_detected(a_err_detected), .err_corrected(a_err_corrected),
        .cnt_clr(cnt_clr), .cw_count(a_cw_count), .err_count(a_err_count)
    );

    crc_checker #(.CORRECT_EN(1'b0), .CNT_W(2)) u_b (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(b_in_ready), .cw_in(cw_in),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .data_out(b_data_out), .syndrome(b_syndrome),
        .err_detected(b_err_detected), .err_corrected(b_err_corrected),
        .cnt_clr(cnt_clr), .cw_count(b_cw_count), .err_count(b_err_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Remainder by long division of the codeword polynomial by 1101
    function automatic logic [2:0] rem(input logic [6:0] v);
        logic [6:0] t;
        t = v;
        for (int i = 6; i >= 3; i--)
            if (t[i]) t = t ^ 7'(7'b0001101 << (i - 3));
        return t[2:0];
    endfunction

    function automatic exp_t model(input logic [6:0] cw);
        exp_t e;
        logic [6:0] c;
        logic [6:0] one;
        e.syn = rem(cw);
        e.err = (e.syn != 3'b000);
        c = cw;
        for (int k = 0; k < 7; k++) begin
            one = 7'(7'd1 << k);
            if (e.err && rem(one) == e.syn) c[k] = ~c[k];
        end
        e.da = c[6:3];
        e.db = cw[6:3];
        return e;
    endfunction

    task automatic check_counters();
        chk("a_cw_count", a_cw_count, ea_cw);
        chk("a_err_count", a_err_count, ea_err);
        chk("b_cw_count", b_cw_count, eb_cw);
        chk("b_err_count", b_err_count, eb_err);
    endtask

    task automatic run_frame(input logic [6:0] cw, input int stall, input bit clr);
        int n;
        exp_t e;
        logic [3:0] hd;
        logic [2:0] hs;
        n = 0;
        while (!a_in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready", a_in_ready, 1);
        cw_in = cw;
        in_valid = 1'b1;
        sb.push_back(model(cw));
        @(posedge clk); #1;
        in_valid = 1'b0;
        cw_in = 7'($urandom);
        chk("busy_in_ready", a_in_ready, 0);
        // n counts edges with the accept edge as the first
        n = 1;
        while (!a_out_valid && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, 8);
        hd = a_data_out;
        hs = a_syndrome;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            cw_in = 7'($urandom);
            @(posedge clk); #1;
            chk("stall_valid", a_out_valid, 1);
            chk("stall_data", a_data_out, hd);
            chk("stall_syn", a_syndrome, hs);
            chk("stall_in_ready", a_in_ready, 0);
        end
        in_valid = 1'b0;
        e = sb.pop_front();
        chk("data_a", a_data_out, e.da);
        chk("data_b", b_data_out, e.db);
        chk("syn_a", a_syndrome, e.syn);
        chk("syn_b", b_syndrome, e.syn);
        chk("err_det", a_err_detected, e.err);
        chk("corr_a", a_err_corrected, e.err);
        chk("corr_b", b_err_corrected, 0);
        out_ready = 1'b1;
        cnt_clr = clr;
        @(posedge clk); #1;
        out_ready = 1'b0;
        cnt_clr = 1'b0;
        if (clr) begin
            ea_cw = 0; ea_err = 0; eb_cw = 0; eb_err = 0;
        end else begin
            if (ea_cw < 65535) ea_cw++;
            if (e.err && ea_err < 65535) ea_err++;
            if (eb_cw < 3) eb_cw++;
            if (e.err && eb_err < 3) eb_err++;
        end
        chk("out_valid_drop", a_out_valid, 0);
        check_counters();
    endtask

    initial begin
        logic [6:0] base;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", a_in_ready, 0);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_data", a_data_out, 0);
        chk("rst_syn", a_syndrome, 0);
        check_counters();
        reset_n = 1'b1;
        @(negedge clk);

        run_frame(7'h4B, 0, 1'b0);
        run_frame(7'h4A, 0, 1'b0);
        run_frame(7'h0B, 0, 1'b0);

        for (int d = 0; d < 16; d++) begin
            base = {4'(d), 3'b000};
            base = base | {4'b0000, rem(base)};
            chk("clean_syn", rem(base), 0);
            run_frame(base, 0, 1'b0);
            for (int k = 0; k < 7; k++)
                run_frame(base ^ 7'(7'd1 << k), 0, 1'b0);
        end

        run_frame(7'h5C, 20, 1'b0);

        cw_in = 7'h4B;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", a_in_ready, 0);
        chk("mid_rst_out_valid", a_out_valid, 0);
        chk("mid_rst_data", a_data_out, 0);
        chk("mid_rst_syn", a_syndrome, 0);
        chk("mid_rst_err", a_err_detected, 0);
        ea_cw = 0; ea_err = 0; eb_cw = 0; eb_err = 0;
        check_counters();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run_frame(7'h0D, 0, 1'b0);
        run_frame(7'h4A, 0, 1'b0);
        run_frame(7'h4B, 0, 1'b0);
        run_frame(7'h0B, 0, 1'b0);
        run_frame(7'h02, 0, 1'b0);
        chk("b_saturated", b_cw_count, 3);
        run_frame(7'h27, 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
